// File: rtl/ula_vram_reader_pkg.sv
// ula_vram_reader_pkg: raster totals and ZX screen address formation shared with the shadow-screen logic
package ula_vram_reader_pkg;
  localparam int H48 = 448;
  localparam int V48 = 312;
  localparam int H128 = 456;
  localparam int V128 = 311;
  localparam int INT_LINE = 248;
  localparam int INT_LEN = 32;
  localparam logic [3:0] ATTR_BASE = 4'b0110;
  function automatic logic [13:0] bitmap_addr(input logic [7:0] y, input logic [4:0] c);
    return {1'b0, y[7:6], y[2:0], y[5:3], c};
  endfunction
  function automatic logic [13:0] attr_addr(input logic [7:0] y, input logic [4:0] c);
    return {ATTR_BASE, y[7:3], c};
  endfunction
endpackage

// File: rtl/ula_vram_reader_if.sv
// ula_vram_reader_if: VRAM port, raster outputs and control inputs of the video reader
interface ula_vram_reader_if;
  logic timming_ula;
  logic [2:0] border;
  logic [13:0] vramaddr;
  logic [7:0] vramdout;
  logic [8:0] hc;
  logic [8:0] vc;
  logic [3:0] color;
  logic display_active;
  logic int_n;
  modport master(input timming_ula, border, vramdout, output vramaddr, hc, vc, color, display_active, int_n);
  modport slave(output timming_ula, border, vramdout, input vramaddr, hc, vc, color, display_active, int_n);
endinterface

// File: rtl/ula_vram_reader_serializer.sv
// ula_pixel_serializer: bitmap/attribute holding, pixel shift register, flash and colour mux
module ula_pixel_serializer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cap,
  input  logic       load,
  input  logic [7:0] din,
  input  logic       flash,
  input  logic       active,
  input  logic [2:0] border,
  output logic [3:0] color,
  output logic       display_active
);
  logic [7:0] bmp, shift, attr;
  logic pix;
  assign pix = shift[7] ^ (attr[7] & flash);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bmp <= '0;
      shift <= '0;
      attr <= '0;
      color <= '0;
      display_active <= 1'b0;
    end else begin
      bmp <= cap ? din : bmp;
      shift <= load ? bmp : {shift[6:0], 1'b0};
      attr <= load ? din : attr;
      color <= active ? {attr[6], pix ? attr[2:0] : attr[5:3]} : {1'b0, border};
      display_active <= active;
    end
endmodule

// File: rtl/ula_vram_reader.sv
// ula_vram_reader: raster counters, interleaved VRAM fetch and frame interrupt for the ULA video path
module ula_vram_reader import ula_vram_reader_pkg::*; #(
  parameter int H48 = ula_vram_reader_pkg::H48,
  parameter int V48 = ula_vram_reader_pkg::V48,
  parameter int H128 = ula_vram_reader_pkg::H128,
  parameter int V128 = ula_vram_reader_pkg::V128,
  parameter int INT_LINE = ula_vram_reader_pkg::INT_LINE,
  parameter int INT_LEN = ula_vram_reader_pkg::INT_LEN
) (
  input logic clk,
  input logic rst_n,
  ula_vram_reader_if.master bus
);
  logic [8:0] hc, vc, ht, vt, f_line;
  logic [4:0] frame, f_cell;
  logic [2:0] ph;
  logic h_wrap, v_wrap, cell0, fetch;
  assign ht = bus.timming_ula ? 9'(H128) : 9'(H48);
  assign vt = bus.timming_ula ? 9'(V128) : 9'(V48);
  assign h_wrap = hc >= ht - 9'd1;
  assign v_wrap = vc >= vt - 9'd1;
  assign ph = hc[2:0];
  // the last 8 clocks of a line prefetch cell 0 of the following line
  assign cell0 = hc >= ht - 9'd8;
  assign f_line = cell0 ? (v_wrap ? 9'd0 : vc + 9'd1) : vc;
  assign f_cell = cell0 ? 5'd0 : hc[7:3] + 5'd1;
  assign fetch = (cell0 || hc < 9'd248) && f_line < 9'd192;
  assign bus.hc = hc;
  assign bus.vc = vc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hc <= '0;
      vc <= '0;
      frame <= '0;
      bus.vramaddr <= '0;
      bus.int_n <= 1'b1;
    end else begin
      hc <= h_wrap ? 9'd0 : hc + 9'd1;
      vc <= h_wrap ? (v_wrap ? 9'd0 : vc + 9'd1) : vc;
      frame <= (h_wrap && v_wrap) ? frame + 5'd1 : frame;
      bus.vramaddr <= (fetch && ph == 3'd3) ? bitmap_addr(f_line[7:0], f_cell) :
                      (fetch && ph == 3'd5) ? attr_addr(f_line[7:0], f_cell) : bus.vramaddr;
      bus.int_n <= !(vc == 9'(INT_LINE) && hc < 9'(INT_LEN));
    end
  ula_pixel_serializer u_ser (
    .clk(clk),
    .rst_n(rst_n),
    .cap(fetch && ph == 3'd5),
    .load(fetch && ph == 3'd7),
    .din(bus.vramdout),
    .flash(frame[4]),
    .active(vc < 9'd192 && hc < 9'd256),
    .border(bus.border),
    .color(bus.color),
    .display_active(bus.display_active)
  );
endmodule

// File: tb/tb_ula_vram_reader.sv
// tb_ula_vram_reader: two scaled-raster instances checked cycle by cycle against a screen-level reference model
module tb_ula_vram_reader;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  ula_vram_reader_if ifa();
  ula_vram_reader_if ifb();
  // A: tall screen for deep line addressing and interrupt; B: two-line frames so flash cycles quickly
  ula_vram_reader #(.H48(264), .V48(70), .H128(272), .V128(69), .INT_LINE(66), .INT_LEN(32))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.master));
  ula_vram_reader #(.H48(264), .V48(2), .H128(272), .V128(3), .INT_LINE(1), .INT_LEN(32))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.master));
  logic [7:0] mem [16384];
  always @(posedge clk) begin
    ifa.vramdout <= mem[ifa.vramaddr];
    ifb.vramdout <= mem[ifb.vramaddr];
  end
  logic [8:0] o_hc [2];
  logic [8:0] o_vc [2];
  logic [13:0] o_va [2];
  logic [3:0] o_col [2];
  logic o_da [2];
  logic o_int [2];
  assign o_hc[0] = ifa.hc;
  assign o_hc[1] = ifb.hc;
  assign o_vc[0] = ifa.vc;
  assign o_vc[1] = ifb.vc;
  assign o_va[0] = ifa.vramaddr;
  assign o_va[1] = ifb.vramaddr;
  assign o_col[0] = ifa.color;
  assign o_col[1] = ifb.color;
  assign o_da[0] = ifa.display_active;
  assign o_da[1] = ifb.display_active;
  assign o_int[0] = ifa.int_n;
  assign o_int[1] = ifb.int_n;
  int ht48 [2] = '{264, 264};
  int vt48 [2] = '{70, 2};
  int ht128 [2] = '{272, 272};
  int vt128 [2] = '{69, 3};
  int intl [2] = '{66, 1};
  int hm [2], vm [2], phm [2], pvm [2], frames [2];
  int pbord [2];
  bit tm [2];
  bit pixchk [2];
  int vectors = 0;
  int miscompares = 0;
  function automatic int baddr(int y, int c);
    return (y / 64) * 2048 + (y % 8) * 256 + ((y / 8) % 8) * 32 + c;
  endfunction
  function automatic int aaddr(int y, int c);
    return 6144 + (y / 8) * 32 + c;
  endfunction
  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s dut%0d got %0h want %0h t=%0t", tag, d, obs, exp, $time);
    end
  endtask
  task automatic check(input int d);
    int ht, vt, x, y, c, bm, at, pix, e, nl, ph;
    bit disp;
    ht = tm[d] ? ht128[d] : ht48[d];
    vt = tm[d] ? vt128[d] : vt48[d];
    chk("hc", d, 32'(o_hc[d]), hm[d]);
    chk("vc", d, 32'(o_vc[d]), vm[d]);
    e = (pvm[d] == intl[d] && phm[d] < 32) ? 0 : 1;
    chk("int_n", d, 32'(o_int[d]), e);
    if (!pixchk[d]) return;
    disp = pvm[d] < 192 && phm[d] < 256;
    chk("display_active", d, 32'(o_da[d]), 32'(disp));
    if (disp) begin
      x = phm[d];
      y = pvm[d];
      c = x / 8;
      if (frames[d] == 0 && y == 0 && c == 0) begin
        bm = 0;
        at = 0;
      end else begin
        bm = mem[baddr(y, c)];
        at = mem[aaddr(y, c)];
      end
      pix = ((bm >> (7 - x % 8)) & 1) ^ ((at >> 7) & (frames[d] >> 4) & 1);
      e = ((at >> 6) & 1) * 8 + (pix != 0 ? at & 7 : (at >> 3) & 7);
    end else e = pbord[d];
    chk("color", d, 32'(o_col[d]), e);
    ph = hm[d] % 8;
    if (hm[d] >= ht - 8) begin
      c = 0;
      nl = (vm[d] >= vt - 1) ? 0 : vm[d] + 1;
    end else begin
      c = hm[d] / 8 + 1;
      nl = vm[d];
    end
    if (ph >= 4 && nl < 192 && (hm[d] >= ht - 8 || hm[d] < 248))
      chk("vramaddr", d, 32'(o_va[d]), ph < 6 ? baddr(nl, c) : aaddr(nl, c));
  endtask
  task automatic tick();
    @(posedge clk);
    pbord[0] = ifa.border;
    pbord[1] = ifb.border;
    for (int d = 0; d < 2; d++) begin
      int ht, vt;
      ht = tm[d] ? ht128[d] : ht48[d];
      vt = tm[d] ? vt128[d] : vt48[d];
      phm[d] = hm[d];
      pvm[d] = vm[d];
      if (hm[d] >= ht - 1) begin
        hm[d] = 0;
        if (vm[d] >= vt - 1) begin
          vm[d] = 0;
          frames[d]++;
        end else vm[d]++;
      end else hm[d]++;
    end
    #1;
    for (int d = 0; d < 2; d++) check(d);
    ifa.border = 3'($urandom);
    ifb.border = 3'($urandom);
  endtask
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_hc", d, 32'(o_hc[d]), 0);
      chk("rst_vc", d, 32'(o_vc[d]), 0);
      chk("rst_int_n", d, 32'(o_int[d]), 1);
      chk("rst_color", d, 32'(o_col[d]), 0);
      chk("rst_display_active", d, 32'(o_da[d]), 0);
      chk("rst_vramaddr", d, 32'(o_va[d]), 0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      hm[d] = 0;
      vm[d] = 0;
      frames[d] = 0;
    end
  endtask
  task automatic set_tm(input int d, input bit v);
    tm[d] = v;
    if (d == 0) ifa.timming_ula = v;
    else ifb.timming_ula = v;
  endtask
  task automatic wait_hc(input int d, input int v);
    for (int i = 0; i < 1000 && o_hc[d] != 9'(v); i++) tick();
    chk("reach_hc", d, 32'(o_hc[d]), v);
  endtask
  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
    mem[baddr(0, 1)] = 8'hA5;
    mem[aaddr(0, 1)] = 8'h47;
    mem[baddr(1, 5)] = 8'hFF;
    mem[aaddr(1, 5)] = 8'h87;
    mem[baddr(65, 3)] = 8'h3C;
    for (int d = 0; d < 2; d++) begin
      set_tm(d, 1'b0);
      pixchk[d] = 1'b1;
    end
    ifa.border = 3'd5;
    ifb.border = 3'd2;
    do_reset();
    repeat (18600) tick();
    do_reset();
    wait_hc(0, 100);
    set_tm(0, 1'b1);
    wait_hc(1, 100);
    set_tm(1, 1'b1);
    repeat (1500) tick();
    // dropping to 48K totals while hc already exceeds the new limit must wrap immediately
    wait_hc(1, 268);
    set_tm(1, 1'b0);
    tick();
    chk("ge_wrap", 1, 32'(o_hc[1]), 0);
    pixchk[1] = 1'b0;
    repeat (600) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
